// File: rtl/debug_overlay_multi.sv
// ---------------------------------------------------------------------------
// debug_overlay_multi
//
// Purpose:
//   Debug overlay for the raybox-zero display path. It draws CHANNELS
//   fixed-point vectors as rows of bit cells in the top-right corner of the
//   view. Values are captured once per frame into snapshot registers, so the
//   picture never tears mid-frame. Bits that changed at a capture are
//   highlighted for HOLD_FRAMES frames. The overlay can be frozen, or toggled
//   on and off. The top level muxes debug_rgb over the scene colour, with the
//   scene colour delayed by one clock to line up.
//
// Ports:
//   clk              in   1               pixel clock
//   reset_n          in   1               asynchronous active-low reset
//   hpos             in   10              current pixel column
//   vpos             in   10              current pixel row
//   channel_data     in   CHANNELS*WIDTH  flat live vectors, channel i at
//                                         [i*WIDTH +: WIDTH]
//   freeze           in   1               level; holds snapshots and counters
//   enable_toggle    in   1               level; each rising edge flips enable
//   in_debug_overlay out  1               registered; pixel inside the
//                                         enabled overlay
//   debug_rgb        out  6               registered colour {R,G,B}, 2b each
// ---------------------------------------------------------------------------
module debug_overlay_multi #(
    parameter int H_VIEW        = 640,
    parameter int DEBUG_SCALE   = 3,
    parameter int WIDTH         = 16,
    parameter int QM            = 6,
    parameter int CHANNELS      = 6,
    parameter int GROUP         = 2,
    parameter int HOLD_FRAMES   = 15,
    parameter bit START_ENABLED = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [9:0]                hpos,
    input  logic [9:0]                vpos,
    input  logic [CHANNELS*WIDTH-1:0] channel_data,
    input  logic                      freeze,
    input  logic                      enable_toggle,
    output logic                      in_debug_overlay,
    output logic [5:0]                debug_rgb
);

    localparam int S    = DEBUG_SCALE;
    localparam int W    = WIDTH << S;
    localparam int HS   = H_VIEW - W - 1;
    localparam int R    = CHANNELS + (CHANNELS - 1) / GROUP;
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Per-channel frame state
    logic [WIDTH-1:0] r_snap    [CHANNELS];
    logic [WIDTH-1:0] r_chgMask [CHANNELS];
    logic [7:0]       r_holdCnt [CHANNELS];

    // Enable control
    logic r_togPrev;
    logic r_en;

    // Registered outputs
    logic       r_inOverlay;
    logic [5:0] r_rgb;

    // Combinational helpers
    logic [WIDTH-1:0] w_chData [CHANNELS];
    logic [WIDTH-1:0] w_diff   [CHANNELS];
    logic             w_fs;
    logic             w_togRise;
    logic [10:0]      w_h;
    logic             w_inRegion;
    logic             w_gridline;
    logic [9:0]       w_row;
    logic [IDXW-1:0]  w_bitIdx;
    logic             w_chHit;
    logic [WIDTH-1:0] w_selSnap;
    logic [WIDTH-1:0] w_selMask;
    logic [7:0]       w_selHold;
    logic             w_bitVal;
    logic             w_bitChg;
    logic             w_inNext;
    logic [5:0]       w_rgbNext;

    assign w_fs      = (hpos == 10'd0) && (vpos == 10'd0);
    assign w_togRise = enable_toggle && !r_togPrev;

    // h is an 11-bit two's complement value. Bit 10 is the sign, so the
    // unsigned upper-bound compare is only trusted once the sign is clear.
    assign w_h        = {1'b0, hpos} - 11'(HS);
    assign w_inRegion = !w_h[10] && (w_h <= 11'(W)) && (vpos <= 10'(R << S));
    assign w_gridline = (w_h[S-1:0] == '0) || (vpos[S-1:0] == '0);
    assign w_row      = vpos >> S;

    // MSB is leftmost. Column WIDTH (the right border) wraps here, but that
    // column is always a gridline, so the wrapped index is never displayed.
    assign w_bitIdx   = IDXW'((WIDTH - 1) - int'(w_h >> S));

    // Unpack the flat channel bus and form the per-channel change vectors
    // against the current snapshot.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_chData[i] = channel_data[i*WIDTH +: WIDTH];
            w_diff[i]   = channel_data[i*WIDTH +: WIDTH] ^ r_snap[i];
        end
    end

    // Map the cell row onto a channel. Channel i sits on row i + i/GROUP.
    // The row numbers are elaboration-time constants, so this is only a set
    // of equality compares.
    always_comb begin
        w_chHit   = 1'b0;
        w_selSnap = '0;
        w_selMask = '0;
        w_selHold = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_row == 10'(i + i / GROUP)) begin
                w_chHit   = 1'b1;
                w_selSnap = r_snap[i];
                w_selMask = r_chgMask[i];
                w_selHold = r_holdCnt[i];
            end
        end
    end

    assign w_bitVal = w_selSnap[w_bitIdx];
    assign w_bitChg = w_selMask[w_bitIdx] && (w_selHold != 8'd0);

    // Colour priority: gridline, then blank row, then highlighted bit, then
    // normal grey cell. Everything is forced to zero while disabled.
    always_comb begin
        w_inNext  = w_inRegion && r_en;
        w_rgbNext = 6'b000000;
        if (w_inNext) begin
            if (w_gridline) begin
                w_rgbNext = (w_h == 11'(QM << S)) ? 6'b101010 : 6'b000000;
            end else if (!w_chHit) begin
                w_rgbNext = 6'b000000;
            end else if (w_bitChg) begin
                w_rgbNext = w_bitVal ? 6'b110000 : 6'b010000;
            end else begin
                w_rgbNext = w_bitVal ? 6'b111111 : 6'b010101;
            end
        end
    end

    // Once-per-frame capture. A fresh change replaces the mask and restarts
    // the hold count. Otherwise the count runs down, and the mask is cleared
    // on the step that takes the count to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_snap[i]    <= '0;
                r_chgMask[i] <= '0;
                r_holdCnt[i] <= '0;
            end
        end else if (w_fs && !freeze) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_snap[i] <= w_chData[i];
                if (w_diff[i] != '0) begin
                    r_chgMask[i] <= w_diff[i];
                    r_holdCnt[i] <= 8'(HOLD_FRAMES);
                end else if (r_holdCnt[i] != 8'd0) begin
                    r_holdCnt[i] <= r_holdCnt[i] - 8'd1;
                    if (r_holdCnt[i] == 8'd1) begin
                        r_chgMask[i] <= '0;
                    end
                end
            end
        end
    end

    // Enable toggles on each rising edge of enable_toggle. This is
    // independent of the frame strobe, so both can act in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_togPrev <= 1'b0;
            r_en      <= START_ENABLED;
        end else begin
            r_togPrev <= enable_toggle;
            if (w_togRise) begin
                r_en <= !r_en;
            end
        end
    end

    // Output register. This gives one clock of latency from hpos/vpos.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inOverlay <= 1'b0;
            r_rgb       <= 6'b000000;
        end else begin
            r_inOverlay <= w_inNext;
            r_rgb       <= w_rgbNext;
        end
    end

    assign in_debug_overlay = r_inOverlay;
    assign debug_rgb        = r_rgb;

endmodule
